// File: rtl/spike_pkg.sv
// Shared definitions for the spike collector: channel FSM states,
// default counter width and the winner-index width helper.
package spike_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } rx_state_t;

    localparam int DEFAULT_CNT_W = 8;

    // Width of an index into n channels; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_rx_channel.sv
// One output-neuron receiver: synchronises the asynchronous request,
// closes the four-phase handshake and counts one spike per handshake
// into a saturating counter with a sticky saturation flag.
module spike_rx_channel
    import spike_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             clear,
    output logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_seen;
    logic                   take_spike;
    rx_state_t              state;

    assign req_seen   = sync_q[SYNC_STAGES-1];
    assign take_spike = (state == IDLE) && req_seen;

    // Multi-flop synchroniser bringing the asynchronous request into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
        end
    end

    // Handshake FSM plus counter: a spike is taken on the IDLE->ACKED edge; a clear
    // arriving on that same edge opens the new window with this spike already in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ack   <= 1'b0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_seen) begin
                        state <= ACKED;
                        ack   <= 1'b1;
                    end
                end
                ACKED: begin
                    if (!req_seen) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
            endcase

            if (clear) begin
                count <= take_spike ? CNT_W'(1) : '0;
                sat   <= 1'b0;
            end else if (take_spike) begin
                if (count == CNT_MAX) begin
                    sat <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spike_collector.sv
// Output-layer spike collector: one handshake receiver per neuron plus
// registered winner (argmax, lowest index on ties) and tie detection.
module spike_collector
    import spike_pkg::*;
#(
    parameter int NEURON_OUT  = 2,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = idx_width(NEURON_OUT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NEURON_OUT-1:0]       req_in,
    output logic [NEURON_OUT-1:0]       ack_in,
    input  logic                        clear,
    output logic [NEURON_OUT*CNT_W-1:0] count,
    output logic [NEURON_OUT-1:0]       sat,
    output logic [IDX_W-1:0]            winner,
    output logic                        winner_valid,
    output logic                        tie
);

    logic [CNT_W-1:0] ch_count [NEURON_OUT];
    logic [CNT_W-1:0] best_count;
    logic [IDX_W-1:0] best_idx;
    int               n_at_max;

    for (genvar g = 0; g < NEURON_OUT; g++) begin : g_ch
        spike_rx_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_rx (
            .clk   (clk),
            .rst   (rst),
            .req   (req_in[g]),
            .clear (clear),
            .ack   (ack_in[g]),
            .count (ch_count[g]),
            .sat   (sat[g])
        );
        assign count[g*CNT_W +: CNT_W] = ch_count[g];
    end

    // Argmax over the counters; strict compare keeps the lowest index on equal counts.
    always_comb begin
        best_count = '0;
        best_idx   = '0;
        n_at_max   = 0;
        for (int i = 0; i < NEURON_OUT; i++) begin
            if (ch_count[i] > best_count) begin
                best_count = ch_count[i];
                best_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NEURON_OUT; i++) begin
            if (ch_count[i] == best_count) begin
                n_at_max = n_at_max + 1;
            end
        end
    end

    // Register the classification result so it trails the counters by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            winner       <= '0;
            winner_valid <= 1'b0;
            tie          <= 1'b0;
        end else begin
            winner       <= best_idx;
            winner_valid <= (best_count != '0);
            tie          <= (best_count != '0) && (n_at_max >= 2);
        end
    end

endmodule

// File: tb/tb_spike_collector.sv
// Scoreboard bench for spike_collector: handshake drivers push the expected
// per-spike result, a monitor pops it whenever an ack rises.
module tb_spike_collector;

    localparam int NEURON_OUT = 2;
    localparam int CNT_W      = 8;
    localparam int LAT        = 3;
    localparam int CNT_MAX    = 255;

    typedef struct {
        int cnt;
        int sat;
        int cyc;
    } exp_t;

    logic                        clk;
    logic                        rst;
    logic [NEURON_OUT-1:0]       req_in;
    logic [NEURON_OUT-1:0]       ack_in;
    logic                        clear;
    logic [NEURON_OUT*CNT_W-1:0] count;
    logic [NEURON_OUT-1:0]       sat;
    logic [0:0]                  winner;
    logic                        winner_valid;
    logic                        tie;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   model_cnt [NEURON_OUT];
    int   model_sat [NEURON_OUT];
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    spike_collector #(
        .NEURON_OUT  (NEURON_OUT),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .ack_in       (ack_in),
        .clear        (clear),
        .count        (count),
        .sat          (sat),
        .winner       (winner),
        .winner_valid (winner_valid),
        .tie          (tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int act, input int req_v);
        n_cmp++;
        if (act != req_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    function automatic int dut_count(input int ch);
        return int'(count[ch*CNT_W +: CNT_W]);
    endfunction

    // Reference model: one completed handshake adds one spike, saturating at the top.
    function automatic exp_t predict(input int ch, input int ack_cyc);
        exp_t e;
        if (model_cnt[ch] == CNT_MAX) model_sat[ch] = 1;
        else model_cnt[ch] = model_cnt[ch] + 1;
        e.cnt = model_cnt[ch];
        e.sat = model_sat[ch];
        e.cyc = ack_cyc;
        return e;
    endfunction

    task automatic push_exp(input int ch, input exp_t e);
        if (ch == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic model_zero();
        for (int i = 0; i < NEURON_OUT; i++) begin
            model_cnt[i] = 0;
            model_sat[i] = 0;
        end
    endtask

    task automatic wait_ack(input int ch, input logic level, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ack_in[ch] == level) seen = 1'b1;
        end
        if (!seen) cmp({name, "_timeout"}, 0, 1);
    endtask

    // One full four-phase handshake on a channel, holding req for extra cycles after ack.
    task automatic applyStimulus(input int ch, input int hold);
        int c;
        @(posedge clk);
        #1;
        push_exp(ch, predict(ch, cyc + LAT));
        req_in[ch] = 1'b1;
        wait_ack(ch, 1'b1, "ack_rise");
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #1;
        req_in[ch] = 1'b0;
        c = cyc;
        wait_ack(ch, 1'b0, "ack_fall");
        cmp("ack_fall_latency", cyc, c + LAT);
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        model_zero();
    endtask

    // Quiescent check of counters, sat flags and the classification outputs.
    task automatic checkOutput(input string tag);
        int maxv, widx, nmax;
        repeat (2) @(posedge clk);
        @(negedge clk);
        maxv = 0;
        widx = 0;
        nmax = 0;
        for (int i = 0; i < NEURON_OUT; i++) if (model_cnt[i] > maxv) maxv = model_cnt[i];
        for (int i = NEURON_OUT - 1; i >= 0; i--) if (model_cnt[i] == maxv) begin
            widx = (maxv == 0) ? 0 : i;
            nmax++;
        end
        for (int i = 0; i < NEURON_OUT; i++) begin
            cmp($sformatf("%s_count%0d", tag, i), dut_count(i), model_cnt[i]);
            cmp($sformatf("%s_sat%0d", tag, i), int'(sat[i]), model_sat[i]);
        end
        cmp({tag, "_winner"}, int'(winner), widx);
        cmp({tag, "_winner_valid"}, int'(winner_valid), (maxv != 0) ? 1 : 0);
        cmp({tag, "_tie"}, int'(tie), (maxv != 0 && nmax >= 2) ? 1 : 0);
    endtask

    // Monitor: every ack rising edge is a DUT output event matched against the scoreboard.
    initial begin
        logic [NEURON_OUT-1:0] prev;
        exp_t e;
        bit   have;
        prev = '0;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NEURON_OUT; ch++) begin
                if (ack_in[ch] && !prev[ch]) begin
                    have = (ch == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                    n_cmp++;
                    if (!have) begin
                        n_fail++;
                        $display("[TB] FAIL unexpected_ack: channel %0d acked with no spike pending (cycle %0d)", ch, cyc);
                    end else begin
                        n_cmp--;
                        e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        cmp($sformatf("ev_count%0d", ch), dut_count(ch), e.cnt);
                        cmp($sformatf("ev_sat%0d", ch), int'(sat[ch]), e.sat);
                        cmp($sformatf("ev_ack_latency%0d", ch), cyc, e.cyc);
                    end
                end
            end
            prev = ack_in;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        rst    = 1'b1;
        req_in = '0;
        clear  = 1'b0;
        model_zero();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("reset_ack", int'(ack_in), 0);
        checkOutput("reset");

        $display("[TB] single spike on channel 0");
        applyStimulus(0, 0);
        checkOutput("single");

        $display("[TB] held request on channel 1");
        applyStimulus(1, 20);
        checkOutput("held");

        $display("[TB] alternating pattern run");
        do_clear();
        for (int k = 0; k < 100; k++) applyStimulus(k % 2, 0);
        checkOutput("pattern_tie");
        applyStimulus(1, 0);
        checkOutput("pattern_extra");

        $display("[TB] randomized concurrent traffic");
        do_clear();
        fork
            begin
                int n0 = $urandom_range(10, 25);
                for (int k = 0; k < n0; k++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    applyStimulus(0, $urandom_range(0, 4));
                end
            end
            begin
                int n1 = $urandom_range(10, 25);
                for (int k = 0; k < n1; k++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    applyStimulus(1, $urandom_range(0, 4));
                end
            end
        join
        checkOutput("random");

        $display("[TB] saturation on channel 0");
        do_clear();
        for (int k = 0; k < 260; k++) applyStimulus(0, 0);
        checkOutput("saturated");
        do_clear();
        checkOutput("sat_cleared");

        $display("[TB] clear colliding with a count edge");
        applyStimulus(0, 0);
        @(posedge clk);
        #1;
        c = cyc;
        model_zero();
        push_exp(1, predict(1, c + LAT));
        req_in[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        wait_ack(1, 1'b1, "collision_ack");
        @(posedge clk);
        #1 req_in[1] = 1'b0;
        wait_ack(1, 1'b0, "collision_fall");
        checkOutput("collision");

        $display("[TB] reset during a handshake");
        @(posedge clk);
        #1;
        push_exp(0, predict(0, cyc + LAT));
        req_in[0] = 1'b1;
        wait_ack(0, 1'b1, "pre_reset_ack");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        c = cyc;
        model_zero();
        @(negedge clk);
        cmp("reset_mid_ack0", int'(ack_in[0]), 0);
        cmp("reset_mid_count", int'(count), 0);
        push_exp(0, predict(0, c + LAT));
        wait_ack(0, 1'b1, "post_reset_ack");
        @(posedge clk);
        #1 req_in[0] = 1'b0;
        wait_ack(0, 1'b0, "post_reset_fall");
        checkOutput("after_reset");

        repeat (4) @(posedge clk);
        cmp("pending_q0", exp_q0.size(), 0);
        cmp("pending_q1", exp_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_collector.md
# spike_collector

Clocked receiver for the output layer of the spiking network. Terminates the four-phase req/ack handshake on each output neuron: it synchronises each request, acknowledges it and counts one spike per completed handshake. It then reports per-neuron spike counts and the winning (most active) neuron for classification. It sits between the asynchronous network's output requests and the synchronous readout logic.

## Interface
- NEURON_OUT, 2, number of output neurons/channels
- CNT_W, 8, width of each per-channel spike counter
- SYNC_STAGES, 2, flip-flops in each req synchroniser (≥2)
- IDX_W, $clog2(NEURON_OUT) (min 1), width of winner index (derived)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_in  in  NEURON_OUT  asynchronous spike requests from output neurons
- ack_in  out  NEURON_OUT  acknowledge to output neurons, registered
- clear  in  1  synchronous pulse: zero all counters (start new window)
- count  out  NEURON_OUT*CNT_W  packed counters, channel i at [i*CNT_W +: CNT_W]
- sat  out  NEURON_OUT  sticky per-channel saturation flag
- winner  out  IDX_W  index of channel with highest count
- winner_valid  out  1  high when any count is nonzero
- tie  out  1  high when ≥2 channels share the maximum nonzero count

## Operation
- Handshake per channel, four-phase: req↑ → ack↑ → req↓ → ack↓. A spike is counted exactly once per handshake.
- Per-channel FSM (states IDLE, ACKED):
  - IDLE: ack=0. Synchronised req=1 → ACKED, ack←1, count increments on the same edge.
  - ACKED: ack=1. Synchronised req=0 → IDLE, ack←0. req staying high holds ACKED with no further counts.
- Counters saturate at 2^CNT_W−1. An increment at max holds the value and sets sat[i]. sat clears only on clear or rst.
- clear zeroes all counts and sat. It does not disturb the FSMs or ack.
- Same-cycle clear and increment on a channel → count=1 (the spike belongs to the new window).
- Winner: maximum count wins; on equal counts the lowest index wins.
  - winner_valid=0 and winner=0 when all counts are zero.
  - tie=1 iff the maximum is nonzero and shared by two or more channels.
- Channels are fully independent; simultaneous requests on all channels are each counted.

## Timing
- Reset values: ack_in=0, count=0, sat=0, winner=0, winner_valid=0, tie=0. All FSMs IDLE, synchronisers 0.
- req↑ to ack↑: SYNC_STAGES+1 cycles (3 with defaults). req↓ to ack↓: same latency.
- Count update is visible on the same edge that ack rises.
- winner/winner_valid/tie are registered: they reflect counts one cycle later (count edge +1).
- A req pulse shorter than SYNC_STAGES+1 cycles is a protocol violation; behaviour is undefined and not checked.
- Reset mid-handshake: ack drops to 0 on the reset edge and the FSM goes IDLE. A req still high after reset deasserts is accepted as a new spike.
- Throughput: at most one spike per channel per 2·(SYNC_STAGES+1) cycles.

## Structure
- Shared package spike_pkg: rx_state_t enum {IDLE, ACKED}, default CNT_W, and a helper function for the index width.
- Sub-module spike_rx_channel (one per neuron, via generate):
  - contents: synchroniser, FSM, saturating counter, sat flag
  - ports: clk, rst, req, clear, ack, count, sat
- Top level holds the generate loop and the registered argmax/tie logic.

## Test plan
- Single spike: after reset, raise req_in[0] and hold until ack_in[0]; drop req; wait for ack↓.
  - ack_in[0]↑ exactly 3 cycles after req↑.
  - count[0]=1; winner=0, winner_valid=1 one cycle later.
- Held request: req_in[1] high for 20 cycles, then low → count[1]=1 only, with one ack pulse.
- Pattern run: handshake driver sends 100 spikes cycling channels 0,1,0,1,… → count[0]=50, count[1]=50, tie=1, winner=0. One extra spike on ch1 → winner=1, tie=0.
- Saturation: 260 handshakes on ch0 → count[0]=255, sat[0]=1. Then clear → count[0]=0, sat[0]=0, winner_valid=0.
- Clear collision: assert clear on the same edge ch1's ack rises → count[1]=1, all other counts 0.
- Reset mid-handshake: pulse rst while ack_in[0]=1 with req held high.
  - ack_in[0]=0 and count=0 on the reset edge.
  - After rst deasserts: ack↑ again 3 cycles later, count[0]=1.
